spi_cmd_ctrl: RTL and testbench

Command sequencer between the 16-bit SPI slave shifter and the synth's control register bank. It parses word-framed SPI traffic from the SAM host into command and data phases, issues register writes or reads with auto-incrementing addresses, and stages readback words for the shifter's MISO path. It also flags framing errors.

---
 rtl/spi_cmd_ctrl.sv | 161 ++++++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_ctrl.sv
// Command sequencer between the 16-bit SPI slave shifter and the control register bank.
// Parses command/data words, issues auto-incrementing register writes/reads and stages readback words.
module spi_cmd_ctrl #(
  parameter int ADDR_W = 7,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_active,
  input  logic              rx_valid,
  input  logic [15:0]       rx_word,
  output logic [15:0]       tx_word,
  output logic              reg_we,
  output logic              reg_re,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [15:0]       reg_wdata,
  input  logic [15:0]       reg_rdata,
  output logic              busy,
  output logic              overrun,
  output logic [7:0]        abort_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_WDATA = 3'd2,
    S_RDATA = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ZERO = '0;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   w_ptr;
  logic [LEN_W-1:0]    r_rem;
  logic [LEN_W-1:0]    w_rem;
  logic                r_we;
  logic                w_we;
  logic                r_re;
  logic                w_re;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr;
  logic [15:0]         r_wdata;
  logic [15:0]         w_wdata;
  logic [15:0]         r_tx;
  logic [15:0]         w_tx;
  logic                r_busy;
  logic                r_ovr;
  logic                w_ovr;
  logic [7:0]          r_abort;
  logic [7:0]          w_abort;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // r_rem holds words still to transfer minus one; reaching zero on a word ends the burst.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr       = r_ptr;
    w_rem       = r_rem;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_ovr       = r_ovr;
    w_abort     = r_abort;
    if (!cs_active) begin
      // Chip select dropping always wins; any word arriving in this cycle is discarded.
      w_state_nxt = S_IDLE;
      if ((r_state == S_WDATA || r_state == S_RDATA) && r_abort != 8'hFF)
        w_abort = r_abort + 8'd1;
    end else begin
      unique case (r_state)
        S_IDLE: w_state_nxt = S_CMD;
        S_CMD: begin
          if (rx_valid) begin
            w_ptr = rx_word[8 +: ADDR_W];
            w_rem = rx_word[LEN_W-1:0];
            w_ovr = 1'b0;
            if (rx_word[15]) begin
              w_re        = 1'b1;
              w_addr      = rx_word[8 +: ADDR_W];
              w_state_nxt = S_RDATA;
            end else begin
              w_state_nxt = S_WDATA;
            end
          end
        end
        S_WDATA: begin
          if (rx_valid) begin
            w_we    = 1'b1;
            w_addr  = r_ptr;
            w_wdata = rx_word;
            w_ptr   = r_ptr + ADDR_ONE;
            if (r_rem == LEN_ZERO) w_state_nxt = S_DONE;
            else                   w_rem = r_rem - LEN_ONE;
          end
        end
        S_RDATA: begin
          if (rx_valid) begin
            if (r_rem == LEN_ZERO) begin
              w_state_nxt = S_DONE;
            end else begin
              w_rem  = r_rem - LEN_ONE;
              w_ptr  = r_ptr + ADDR_ONE;
              w_addr = r_ptr + ADDR_ONE;
              w_re   = 1'b1;
            end
          end
        end
        S_DONE: if (rx_valid) w_ovr = 1'b1;
        default: w_state_nxt = S_IDLE;
      endcase
    end
    // Readback is captured the cycle after reg_re; outside RDATA the shifter sees all ones.
    if (w_state_nxt == S_RDATA) w_tx = r_re ? reg_rdata : r_tx;
    else                        w_tx = 16'hFFFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= '0;
      r_rem   <= '0;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 16'h0000;
      r_tx    <= 16'hFFFF;
      r_busy  <= 1'b0;
      r_ovr   <= 1'b0;
      r_abort <= 8'd0;
    end else begin
      r_ptr   <= w_ptr;
      r_rem   <= w_rem;
      r_we    <= w_we;
      r_re    <= w_re;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_tx    <= w_tx;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_ovr   <= w_ovr;
      r_abort <= w_abort;
    end
  end

  assign tx_word   = r_tx;
  assign reg_we    = r_we;
  assign reg_re    = r_re;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign busy      = r_busy;
  assign overrun   = r_ovr;
  assign abort_cnt = r_abort;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: writes, wrapping bursts, reads, aborts, collisions and reset.
module tb_spi_cmd_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        cs_active;
  logic        rx_valid;
  logic [15:0] rx_word;
  logic [15:0] tx_word;
  logic        reg_we;
  logic        reg_re;
  logic [6:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;
  logic        busy;
  logic        overrun;
  logic [7:0]  abort_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Register bank model: every address reads back as addr + 0x100.
  assign reg_rdata = 16'h0100 + {9'd0, reg_addr};

  spi_cmd_ctrl #(.ADDR_W(7), .LEN_W(8)) dut (
    .clk(clk), .reset(reset), .cs_active(cs_active), .rx_valid(rx_valid),
    .rx_word(rx_word), .tx_word(tx_word), .reg_we(reg_we), .reg_re(reg_re),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .busy(busy), .overrun(overrun), .abort_cnt(abort_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present one word for a single cycle; returns just after the capturing edge.
  task automatic push_word(input logic [15:0] w);
    rx_valid = 1'b1;
    rx_word  = w;
    tick();
    rx_valid = 1'b0;
    rx_word  = 16'h0000;
  endtask

  task automatic test_reset();
    reset = 1'b1; cs_active = 1'b0; rx_valid = 1'b0; rx_word = 16'h0000;
    idle(2);
    reset = 1'b0;
    n_vec++; if (tx_word !== 16'hFFFF) begin n_bad++; $display("FAIL reset_tx got %h want ffff", tx_word); end
    n_vec++; if ({reg_we, reg_re, busy, overrun} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got %b want 0000", {reg_we, reg_re, busy, overrun}); end
    n_vec++; if ({reg_addr, reg_wdata, abort_cnt} !== 31'd0) begin n_bad++; $display("FAIL reset_regs got %h/%h/%h want 0", reg_addr, reg_wdata, abort_cnt); end
  endtask

  task automatic test_single_write();
    cs_active = 1'b1;
    tick();
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL sw_busy_rise got %b want 1", busy); end
    push_word(16'h0A00);
    n_vec++; if (reg_we !== 1'b0) begin n_bad++; $display("FAIL sw_cmd_no_we got %b want 0", reg_we); end
    idle(3);
    push_word(16'h1234);
    n_vec++; if ({reg_we, reg_addr, reg_wdata} !== {1'b1, 7'h0A, 16'h1234}) begin n_bad++; $display("FAIL sw_we got we=%b a=%h d=%h want 1/0a/1234", reg_we, reg_addr, reg_wdata); end
    tick();
    n_vec++; if (reg_we !== 1'b0) begin n_bad++; $display("FAIL sw_we_pulse got %b want 0", reg_we); end
    cs_active = 1'b0;
    tick();
    n_vec++; if ({busy, abort_cnt} !== 9'd0) begin n_bad++; $display("FAIL sw_end got busy=%b abort=%0d want 0/0", busy, abort_cnt); end
  endtask

  task automatic test_burst_wrap();
    logic [6:0] exp_a [3];
    exp_a[0] = 7'h7F; exp_a[1] = 7'h00; exp_a[2] = 7'h01;
    cs_active = 1'b1;
    tick();
    push_word(16'h7F02);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      push_word(16'hA000 + 16'(i));
      n_vec++; if ({reg_we, reg_addr, reg_wdata} !== {1'b1, exp_a[i], 16'hA000 + 16'(i)}) begin n_bad++; $display("FAIL wrap_we%0d got we=%b a=%h d=%h want 1/%h/%h", i, reg_we, reg_addr, reg_wdata, exp_a[i], 16'hA000 + 16'(i)); end
      idle(2);
    end
    n_vec++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL wrap_ovr_pre got %b want 0", overrun); end
    push_word(16'hDEAD);
    n_vec++; if ({reg_we, overrun} !== 2'b01) begin n_bad++; $display("FAIL wrap_overrun got we=%b ovr=%b want 0/1", reg_we, overrun); end
    cs_active = 1'b0;
    idle(2);
    n_vec++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL wrap_ovr_sticky got %b want 1", overrun); end
  endtask

  task automatic test_burst_read();
    cs_active = 1'b1;
    tick();
    push_word(16'h8501);
    n_vec++; if ({reg_re, reg_we, reg_addr, tx_word} !== {2'b10, 7'h05, 16'hFFFF}) begin n_bad++; $display("FAIL rd_re0 got re=%b we=%b a=%h tx=%h want 1/0/05/ffff", reg_re, reg_we, reg_addr, tx_word); end
    tick();
    n_vec++; if ({reg_re, tx_word} !== {1'b0, 16'h0105}) begin n_bad++; $display("FAIL rd_tx0 got re=%b tx=%h want 0/0105", reg_re, tx_word); end
    n_vec++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rd_ovr_clear got %b want 0", overrun); end
    idle(3);
    push_word(16'h0000);
    n_vec++; if ({reg_re, reg_addr, tx_word} !== {1'b1, 7'h06, 16'h0105}) begin n_bad++; $display("FAIL rd_re1 got re=%b a=%h tx=%h want 1/06/0105", reg_re, reg_addr, tx_word); end
    tick();
    n_vec++; if (tx_word !== 16'h0106) begin n_bad++; $display("FAIL rd_tx1 got %h want 0106", tx_word); end
    idle(3);
    push_word(16'h0000);
    n_vec++; if ({reg_re, busy, tx_word} !== {2'b01, 16'hFFFF}) begin n_bad++; $display("FAIL rd_done got re=%b busy=%b tx=%h want 0/1/ffff", reg_re, busy, tx_word); end
    cs_active = 1'b0;
    tick();
    n_vec++; if ({busy, abort_cnt} !== 9'd0) begin n_bad++; $display("FAIL rd_end got busy=%b abort=%0d want 0/0", busy, abort_cnt); end
  endtask

  task automatic test_abort();
    int n_we;
    n_we = 0;
    cs_active = 1'b1;
    tick();
    push_word(16'h2003);
    idle(2);
    push_word(16'hBEEF);
    n_we += int'(reg_we);
    n_vec++; if ({reg_addr, reg_wdata} !== {7'h20, 16'hBEEF}) begin n_bad++; $display("FAIL ab_we got a=%h d=%h want 20/beef", reg_addr, reg_wdata); end
    idle(2);
    cs_active = 1'b0;
    tick();
    n_we += int'(reg_we);
    n_vec++; if (n_we !== 1) begin n_bad++; $display("FAIL ab_we_count got %0d want 1", n_we); end
    n_vec++; if ({abort_cnt, busy} !== {8'd1, 1'b0}) begin n_bad++; $display("FAIL ab_cnt got abort=%0d busy=%b want 1/0", abort_cnt, busy); end
    cs_active = 1'b1;
    tick();
    push_word(16'h3000);
    idle(2);
    push_word(16'h5555);
    n_vec++; if ({reg_we, reg_addr, reg_wdata} !== {1'b1, 7'h30, 16'h5555}) begin n_bad++; $display("FAIL ab_next got we=%b a=%h d=%h want 1/30/5555", reg_we, reg_addr, reg_wdata); end
    cs_active = 1'b0;
    tick();
    n_vec++; if ({abort_cnt, overrun} !== {8'd1, 1'b0}) begin n_bad++; $display("FAIL ab_after got abort=%0d ovr=%b want 1/0", abort_cnt, overrun); end
  endtask

  task automatic test_collision();
    cs_active = 1'b1;
    tick();
    push_word(16'h4000);
    idle(2);
    rx_valid  = 1'b1;
    rx_word   = 16'h9999;
    cs_active = 1'b0;
    tick();
    rx_valid = 1'b0;
    n_vec++; if ({reg_we, reg_re, busy} !== 3'b000) begin n_bad++; $display("FAIL col_strobe got we=%b re=%b busy=%b want 000", reg_we, reg_re, busy); end
    n_vec++; if (abort_cnt !== 8'd2) begin n_bad++; $display("FAIL col_abort got %0d want 2", abort_cnt); end
  endtask

  task automatic test_reset_mid_read();
    cs_active = 1'b1;
    tick();
    push_word(16'h8A01);
    tick();
    n_vec++; if (tx_word !== 16'h010A) begin n_bad++; $display("FAIL rst_pre_tx got %h want 010a", tx_word); end
    idle(2);
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_word  = 16'h0000;
    tick();
    reset    = 1'b0;
    rx_valid = 1'b0;
    cs_active = 1'b0;
    n_vec++; if ({reg_we, reg_re, busy, overrun, tx_word} !== {4'b0000, 16'hFFFF}) begin n_bad++; $display("FAIL rst_mid got we=%b re=%b busy=%b ovr=%b tx=%h want 0/0/0/0/ffff", reg_we, reg_re, busy, overrun, tx_word); end
    n_vec++; if ({reg_addr, reg_wdata, abort_cnt} !== 31'd0) begin n_bad++; $display("FAIL rst_mid_regs got %h/%h/%0d want 0", reg_addr, reg_wdata, abort_cnt); end
    tick();
  endtask

  task automatic test_abort_saturation();
    for (int i = 0; i < 256; i++) begin
      cs_active = 1'b1;
      tick();
      push_word(16'h0000);
      tick();
      cs_active = 1'b0;
      tick();
      if (i == 253) begin
        n_vec++; if (abort_cnt !== 8'd254) begin n_bad++; $display("FAIL sat_254 got %0d want 254", abort_cnt); end
      end
    end
    n_vec++; if (abort_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_255 got %0d want 255", abort_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_wrap();
    test_burst_read();
    test_abort();
    test_collision();
    test_reset_mid_read();
    test_abort_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
